cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter RST_CYCLES, 3, cycles cpu_rst is held after start (>=1).
REQ-002 SHALL have parameter MAX_CYCLES, 2000, run-cycle budget before timeout (>=1).
REQ-003 SHALL have parameter HALT_CYCLES, 3, cycles cpu_halt is held before DONE (>=1).
REQ-004 SHALL have parameter CNT_W, 32, width of cycle counter (must hold MAX_CYCLES).
REQ-005 SHALL have port clk input 1: single clock; all state updates on rising edge.
REQ-006 SHALL have port rst input 1: reset, asynchronous, active-high.
REQ-007 SHALL have port start input 1: one-cycle pulse that launches a run; ignored outside IDLE/DONE.
REQ-008 SHALL have port pause input 1: level; freezes CPU and counter while high in RUN.
REQ-009 SHALL have port cpu_done input 1: CPU end-of-program indication (e.g. ecall), sampled in RUN only.
REQ-010 SHALL have port cpu_rst output 1: reset to the CPU under control.
REQ-011 SHALL have port cpu_halt output 1: halt to the CPU under control.
REQ-012 SHALL have port cycle_count output CNT_W: run cycles executed in the current/last run.
REQ-013 SHALL have port busy output 1: high in RESET, RUN, HALT.
REQ-014 SHALL have port done output 1: high in DONE.
REQ-015 SHALL have port timeout output 1: valid in DONE; 1 = ended by budget, 0 = ended by cpu_done.

Function
REQ-016 SHALL implement FSM states IDLE, RESET, RUN, HALT, DONE.
REQ-017 IDLE: cpu_rst=1, cpu_halt=0; start -> RESET, cycle_count cleared to 0, timeout cleared.
REQ-018 RESET: cpu_rst=1 for exactly RST_CYCLES cycles, then -> RUN.
REQ-019 RUN: cpu_rst=0; cpu_halt=pause (combinational from pause and state); cycle_count increments once per cycle with pause=0.
REQ-020 RUN exit: cpu_done=1 with pause=0 -> HALT, timeout=0; that cycle counted.
REQ-021 RUN exit: cycle_count reaching MAX_CYCLES -> HALT, timeout=1; counter saturates at MAX_CYCLES, never wraps.
REQ-022 cpu_done on the same cycle the budget is reached SHALL win: timeout=0.
REQ-023 cpu_done while pause=1 SHALL be ignored.
REQ-024 HALT: cpu_halt=1, cpu_rst=0 for exactly HALT_CYCLES cycles, then -> DONE.
REQ-025 DONE: cpu_halt=1, cpu_rst=0; cycle_count and timeout held; start -> RESET (restart, counter cleared).
REQ-026 start in RESET/RUN/HALT SHALL be ignored.

Reset
REQ-027 rst SHALL force IDLE immediately at any point, including mid-run: cpu_rst=1, cpu_halt=0, cycle_count=0, busy=0, done=0, timeout=0.
REQ-028 After rst deasserts the block SHALL stay in IDLE until start.

Structure
REQ-029 State encoding typedef and default parameter constants SHALL live in the shared package cpu_tb_pkg.
REQ-030 One sub-module, run_timer (loadable down-counter with terminal-count flag), SHALL time RESET and HALT phases.

Verification
REQ-031 rst pulse, start at cycle 2 -> cpu_rst high exactly 3 cycles, then RUN; no cpu_done -> timeout=1, cycle_count=2000, done after 3 halt cycles.
REQ-032 cpu_done at run cycle 50 -> HALT, timeout=0, cycle_count=50.
REQ-033 pause high 10 cycles mid-run, cpu_done pulsed during pause -> cpu_halt high those 10 cycles, count frozen, done ignored.
REQ-034 cpu_done on cycle 2000 -> timeout=0, cycle_count=2000.
REQ-035 rst asserted mid-RUN -> outputs at reset values within same cycle (async); restart from DONE via start clears counter.

Source files
------------

// File: rtl/cpu_tb_pkg.sv
// Shared types and default constants for the CPU run controller.
// State encoding plus timer width used by run_timer.
package cpu_tb_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_HALT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam int RST_CYCLES_D  = 3;
  localparam int MAX_CYCLES_D  = 2000;
  localparam int HALT_CYCLES_D = 3;
  localparam int CNT_W_D       = 32;
  localparam int TMR_W         = 16;

endpackage

// File: rtl/run_timer.sv
// Loadable down-counter with terminal-count flag.
// Times the fixed-length RESET and HALT phases.
module run_timer
  import cpu_tb_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // load wins over decrement; counting stops at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: resets, runs, halts and times a CPU under test.
// Phase lengths come from run_timer; run budget from the cycle counter.
module cpu_run_ctrl
  import cpu_tb_pkg::*;
#(
  parameter int RST_CYCLES  = RST_CYCLES_D,
  parameter int MAX_CYCLES  = MAX_CYCLES_D,
  parameter int HALT_CYCLES = HALT_CYCLES_D,
  parameter int CNT_W       = CNT_W_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             cpu_done,
  output logic             cpu_rst,
  output logic             cpu_halt,
  output logic [CNT_W-1:0] cycle_count,
  output logic             busy,
  output logic             done,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);
  localparam logic [TMR_W-1:0] RST_LD = TMR_W'(RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] HLT_LD = TMR_W'(HALT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             to_q, to_d;
  logic             tmr_ld;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_en;
  logic             tmr_tc;

  run_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_ld),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  // next state, run counter and timer control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    tmr_ld  = 1'b0;
    tmr_val = '0;
    tmr_en  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RESET;
          cnt_d   = '0;
          to_d    = 1'b0;
          tmr_ld  = 1'b1;
          tmr_val = RST_LD;
        end
      end
      S_RESET: begin
        if (tmr_tc) state_d = S_RUN;
        else        tmr_en  = 1'b1;
      end
      S_RUN: begin
        if (!pause && (cnt_q != MAX_C)) begin
          cnt_d = cnt_q + 1'b1;
          if (cpu_done) begin
            state_d = S_HALT;
            to_d    = 1'b0;
            tmr_ld  = 1'b1;
            tmr_val = HLT_LD;
          end else if (cnt_d == MAX_C) begin
            state_d = S_HALT;
            to_d    = 1'b1;
            tmr_ld  = 1'b1;
            tmr_val = HLT_LD;
          end
        end
      end
      S_HALT: begin
        if (tmr_tc) state_d = S_DONE;
        else        tmr_en  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, counter and timeout registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  // outputs decoded from state; halt follows pause while running
  always_comb begin
    cpu_rst  = 1'b0;
    cpu_halt = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (1'b1)
      (state_q == S_IDLE):  cpu_rst = 1'b1;
      (state_q == S_RESET): begin
        cpu_rst = 1'b1;
        busy    = 1'b1;
      end
      (state_q == S_RUN): begin
        cpu_halt = pause;
        busy     = 1'b1;
      end
      (state_q == S_HALT): begin
        cpu_halt = 1'b1;
        busy     = 1'b1;
      end
      (state_q == S_DONE): begin
        cpu_halt = 1'b1;
        done     = 1'b1;
      end
      default: cpu_rst = 1'b1;
    endcase
  end

  assign cycle_count = cnt_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed runs plus random stimulus
// checked every cycle against a phase/age reference model.
module tb_cpu_run_ctrl;
  import cpu_tb_pkg::*;

  localparam int RC = RST_CYCLES_D;
  localparam int MC = MAX_CYCLES_D;
  localparam int HC = HALT_CYCLES_D;
  localparam int CW = CNT_W_D;

  localparam int P_IDLE  = 0;
  localparam int P_RESET = 1;
  localparam int P_RUN   = 2;
  localparam int P_HALT  = 3;
  localparam int P_DONE  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          pause;
  logic          cpu_done;
  logic          cpu_rst;
  logic          cpu_halt;
  logic [CW-1:0] cycle_count;
  logic          busy;
  logic          done;
  logic          timeout;

  int n_chk  = 0;
  int n_pass = 0;

  int m_ph;
  int m_age;
  int m_cnt;
  bit m_to;

  int rst_busy_n;
  logic o_halt;

  cpu_run_ctrl #(
    .RST_CYCLES  (RC),
    .MAX_CYCLES  (MC),
    .HALT_CYCLES (HC),
    .CNT_W       (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .pause       (pause),
    .cpu_done    (cpu_done),
    .cpu_rst     (cpu_rst),
    .cpu_halt    (cpu_halt),
    .cycle_count (cycle_count),
    .busy        (busy),
    .done        (done),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_ph  = P_IDLE;
    m_age = 0;
    m_cnt = 0;
    m_to  = 1'b0;
  endtask

  task automatic m_step(input bit st, input bit ps, input bit dn);
    case (m_ph)
      P_IDLE, P_DONE: begin
        if (st) begin
          m_ph  = P_RESET;
          m_age = 0;
          m_cnt = 0;
          m_to  = 1'b0;
        end
      end
      P_RESET: begin
        m_age++;
        if (m_age == RC) begin
          m_ph  = P_RUN;
          m_age = 0;
        end
      end
      P_RUN: begin
        if (!ps) begin
          m_cnt++;
          if (dn) begin
            m_ph = P_HALT;
            m_to = 1'b0;
          end else if (m_cnt >= MC) begin
            m_ph = P_HALT;
            m_to = 1'b1;
          end
        end
      end
      P_HALT: begin
        m_age++;
        if (m_age == HC) begin
          m_ph  = P_DONE;
          m_age = 0;
        end
      end
      default: m_reset();
    endcase
  endtask

  task automatic check_outs(input bit ps);
    chk("cpu_rst", cpu_rst, m_ph <= P_RESET);
    chk("cpu_halt", cpu_halt,
        (m_ph >= P_HALT) || (m_ph == P_RUN && ps));
    chk("busy", busy, m_ph >= P_RESET && m_ph <= P_HALT);
    chk("done", done, m_ph == P_DONE);
    chk("cycle_count", cycle_count, m_cnt);
    chk("timeout", timeout, m_to);
  endtask

  task automatic cyc(input bit st, input bit ps, input bit dn);
    start    = st;
    pause    = ps;
    cpu_done = dn;
    @(negedge clk);
    check_outs(ps);
    o_halt = cpu_halt;
    if (cpu_rst && busy) rst_busy_n++;
    @(posedge clk);
    m_step(st, ps, dn);
    #1;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    #2;
    m_reset();
    check_outs(pause);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    start    = 1'b0;
    pause    = 1'b0;
    cpu_done = 1'b0;
  endtask

  task automatic run_until_done(input int lim);
    for (int i = 0; i < lim; i++) begin
      if (m_ph == P_DONE) break;
      cyc(1'b0, 1'b0, 1'b0);
    end
    chk("reach_done", done, 1'b1);
  endtask

  task automatic run_to_cnt(input int n, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (m_ph == P_RUN && m_cnt == n) break;
      cyc(m_ph == P_RUN && m_cnt == 10, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int hcnt;
    rst        = 1'b1;
    start      = 1'b0;
    pause      = 1'b0;
    cpu_done   = 1'b0;
    rst_busy_n = 0;
    o_halt     = 1'b0;
    m_reset();
    do_rst();

    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    rst_busy_n = 0;
    cyc(1'b1, 1'b0, 1'b0);
    run_until_done(MC + 100);
    chk("rst_len", rst_busy_n, RC);
    chk("to_budget", timeout, 1'b1);
    chk("cnt_budget", cycle_count, MC);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    cyc(1'b1, 1'b0, 1'b0);
    chk("restart_clr", cycle_count, 0);
    run_to_cnt(49, 200);
    cyc(1'b0, 1'b0, 1'b1);
    run_until_done(50);
    chk("to_done50", timeout, 1'b0);
    chk("cnt_done50", cycle_count, 50);

    cyc(1'b1, 1'b0, 1'b0);
    run_to_cnt(100, 300);
    hcnt = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b1, i == 4);
      hcnt += int'(o_halt);
    end
    chk("pause_halt", hcnt, 10);
    chk("pause_frozen", cycle_count, 100);
    chk("pause_busy", busy, 1'b1);
    run_to_cnt(119, 100);
    cyc(1'b0, 1'b0, 1'b1);
    run_until_done(50);
    chk("to_pause", timeout, 1'b0);
    chk("cnt_pause", cycle_count, 120);

    cyc(1'b1, 1'b0, 1'b0);
    run_to_cnt(MC - 1, MC + 100);
    cyc(1'b0, 1'b0, 1'b1);
    run_until_done(50);
    chk("to_tie", timeout, 1'b0);
    chk("cnt_tie", cycle_count, MC);

    cyc(1'b1, 1'b0, 1'b0);
    run_to_cnt(30, 100);
    pause = 1'b1;
    do_rst();
    chk("arst_cnt", cycle_count, 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("stay_idle", cpu_rst, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    run_to_cnt(5, 50);

    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(599, 0) == 0) begin
        do_rst();
      end else begin
        cyc($urandom_range(24, 0) == 0,
            $urandom_range(3, 0) == 0,
            $urandom_range(59, 0) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
